// File: rtl/sm_uart_hexdump.sv
// Debug UART that dumps a 32-bit word as 8 uppercase hex digits plus CR LF, 8N1.
// Defining SM_UART_PARITY_EN adds an even-parity bit per character (8E1).
`timescale 1ns/1ps
module sm_uart_hexdump #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        txd
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

`ifdef SM_UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_next;
  logic [31:0]     snapshot;
  logic [3:0]      char_idx;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   baud_cnt;
  logic [7:0]      shift;
  logic            baud_wrap;

  // Characters 0..7 are hex digits of the word, MSB nibble first; 8 is CR, 9 is LF.
  function automatic logic [7:0] char_code(input logic [31:0] word, input logic [3:0] idx);
    logic [31:0] shifted;
    logic [3:0]  nib;
    shifted = word << {idx, 2'b00};
    nib     = shifted[31:28];
    if (idx == 4'd8)       return 8'h0D;
    else if (idx == 4'd9)  return 8'h0A;
    else if (nib < 4'd10)  return 8'h30 + {4'h0, nib};
    else                   return 8'h37 + {4'h0, nib};
  endfunction

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    txd        = 1'b1;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = START;
      end
      START: begin
        txd = 1'b0;
        if (baud_wrap) state_next = DATA;
      end
      DATA: begin
        txd = shift[0];
`ifdef SM_UART_PARITY_EN
        if (baud_wrap && bit_idx == 3'd7) state_next = PARITY;
`else
        if (baud_wrap && bit_idx == 3'd7) state_next = STOP;
`endif
      end
`ifdef SM_UART_PARITY_EN
      PARITY: begin
        txd = ^char_code(snapshot, char_idx);
        if (baud_wrap) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_wrap) state_next = (char_idx == 4'd9) ? IDLE : START;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: baud timing, bit/char sequencing and the one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot <= '0;
      char_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      shift    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        baud_cnt <= '0;
        if (start) begin
          snapshot <= data;
          char_idx <= 4'd0;
          bit_idx  <= 3'd0;
          shift    <= char_code(data, 4'd0);
        end
      end else begin
        baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
        if (baud_wrap && state == DATA) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
        if (baud_wrap && state == STOP) begin
          if (char_idx == 4'd9) begin
            done <= 1'b1;
          end else begin
            char_idx <= char_idx + 4'd1;
            shift    <= char_code(snapshot, char_idx + 4'd1);
            bit_idx  <= 3'd0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_uart_hexdump.sv
// Directed self-checking bench for sm_uart_hexdump at BAUD_DIV=4.
// Records txd/busy/done per cycle after each accepted start and decodes the serial stream.
`timescale 1ns/1ps
module tb_sm_uart_hexdump;
  localparam int BD = 4;
`ifdef SM_UART_PARITY_EN
  localparam int CL = 11 * BD;
  localparam int STOP_SLOT = 10;
`else
  localparam int CL = 10 * BD;
  localparam int STOP_SLOT = 9;
`endif
  localparam int FRAME = 10 * CL;

  logic        clk, rst, start, busy, done, txd;
  logic [31:0] data;

  int total, bad;
  logic       tr_txd[1024];
  logic       tr_busy[1024];
  logic       tr_done[1024];
  logic [7:0] dec_bytes[10];
  logic       dec_par[10];
  logic       dec_frame_ok;
  logic [7:0] exp_bytes[10];

  sm_uart_hexdump #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy), .done(done), .txd(txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task step();
    @(posedge clk);
    #1;
  endtask

  // Index 0 of a later capture is the cycle right after the accepting edge.
  task pulse_start(input logic [31:0] w);
    data  = w;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task capture(input int n, input int inj_idx, input logic [31:0] inj_data);
    for (int i = 0; i < n; i++) begin
      tr_txd[i]  = txd;
      tr_busy[i] = busy;
      tr_done[i] = done;
      if (i == inj_idx) begin
        data  = inj_data;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
  endtask

  task decode(input int base);
    dec_frame_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      int o;
      o = base + c * CL;
      if (tr_txd[o + 2] !== 1'b0) dec_frame_ok = 1'b0;
      for (int b = 0; b < 8; b++) dec_bytes[c][b] = tr_txd[o + (1 + b) * BD + 2];
      dec_par[c] = tr_txd[o + 9 * BD + 2];
      if (tr_txd[o + STOP_SLOT * BD + 2] !== 1'b1) dec_frame_ok = 1'b0;
    end
  endtask

  task test_reset();
    logic stayed_high;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    total++; if (txd !== 1'b1)  begin bad++; $display("[TB] FAIL reset_txd: got %b expected 1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    capture(50, -1, 32'h0);
    stayed_high = 1'b1;
    for (int i = 0; i < 50; i++) if (tr_txd[i] !== 1'b1 || tr_busy[i] !== 1'b0) stayed_high = 1'b0;
    total++; if (stayed_high !== 1'b1) begin bad++; $display("[TB] FAIL reset_idle: got %b expected 1", stayed_high); end
  endtask

  task test_full_frame();
    logic busy_ok;
    int   done_cnt;
    exp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    pulse_start(32'h1234ABCD);
    capture(FRAME + 20, -1, 32'h0);
    decode(0);
    total++; if (tr_txd[0] !== 1'b0) begin bad++; $display("[TB] FAIL full_txd_fall: got %b expected 0", tr_txd[0]); end
    for (int c = 0; c < 10; c++) begin
      total++;
      if (dec_bytes[c] !== exp_bytes[c]) begin bad++; $display("[TB] FAIL full_char%0d: got %h expected %h", c, dec_bytes[c], exp_bytes[c]); end
    end
    total++; if (dec_frame_ok !== 1'b1) begin bad++; $display("[TB] FAIL full_framing: got %b expected 1", dec_frame_ok); end
    busy_ok = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      if (i < FRAME && tr_busy[i] !== 1'b1) busy_ok = 1'b0;
      if (i >= FRAME && tr_busy[i] !== 1'b0) busy_ok = 1'b0;
      if (tr_done[i] === 1'b1) done_cnt++;
    end
    total++; if (busy_ok !== 1'b1) begin bad++; $display("[TB] FAIL full_busy_window: got %b expected 1", busy_ok); end
    total++; if (tr_done[FRAME] !== 1'b1) begin bad++; $display("[TB] FAIL full_done_time: got %b expected 1", tr_done[FRAME]); end
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_cnt); end
  endtask

  task test_ignored_start();
    int   done_cnt;
    logic idle_after;
    exp_bytes = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46, 8'h0D, 8'h0A};
    pulse_start(32'h0000000F);
    capture(FRAME + 50, 99, 32'hFFFFFFFF);
    decode(0);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (dec_bytes[c] !== exp_bytes[c]) begin bad++; $display("[TB] FAIL stale_char%0d: got %h expected %h", c, dec_bytes[c], exp_bytes[c]); end
    end
    done_cnt = 0;
    idle_after = 1'b1;
    for (int i = 0; i < FRAME + 50; i++) begin
      if (tr_done[i] === 1'b1) done_cnt++;
      if (i >= FRAME && (tr_busy[i] !== 1'b0 || tr_txd[i] !== 1'b1)) idle_after = 1'b0;
    end
    total++; if (done_cnt != 1) begin bad++; $display("[TB] FAIL stale_done_count: got %0d expected 1", done_cnt); end
    total++; if (tr_done[FRAME] !== 1'b1) begin bad++; $display("[TB] FAIL stale_done_time: got %b expected 1", tr_done[FRAME]); end
    total++; if (idle_after !== 1'b1) begin bad++; $display("[TB] FAIL stale_no_requeue: got %b expected 1", idle_after); end
  endtask

  task test_back_to_back();
    exp_bytes = '{8'h39, 8'h38, 8'h37, 8'h36, 8'h46, 8'h45, 8'h44, 8'h43, 8'h0D, 8'h0A};
    pulse_start(32'h9876FEDC);
    capture(2 * FRAME + 30, FRAME, 32'hDEADBEEF);
    decode(0);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (dec_bytes[c] !== exp_bytes[c]) begin bad++; $display("[TB] FAIL b2b_first_char%0d: got %h expected %h", c, dec_bytes[c], exp_bytes[c]); end
    end
    total++; if (tr_done[FRAME] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first_done: got %b expected 1", tr_done[FRAME]); end
    total++; if (tr_txd[FRAME] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_idle_gap: got %b expected 1", tr_txd[FRAME]); end
    total++; if (tr_txd[FRAME + 1] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_second_start: got %b expected 0", tr_txd[FRAME + 1]); end
    exp_bytes = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    decode(FRAME + 1);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (dec_bytes[c] !== exp_bytes[c]) begin bad++; $display("[TB] FAIL b2b_second_char%0d: got %h expected %h", c, dec_bytes[c], exp_bytes[c]); end
    end
    total++; if (dec_frame_ok !== 1'b1) begin bad++; $display("[TB] FAIL b2b_framing: got %b expected 1", dec_frame_ok); end
    total++; if (tr_done[2 * FRAME + 1] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_done: got %b expected 1", tr_done[2 * FRAME + 1]); end
  endtask

  task test_abort();
    int   done_cnt;
    logic quiet;
    pulse_start(32'h55AA55AA);
    capture(57, -1, 32'h0);
    rst = 1'b1;
    #1;
    total++; if (txd !== 1'b1)  begin bad++; $display("[TB] FAIL abort_txd: got %b expected 1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    step();
    step();
    rst = 1'b0;
    capture(FRAME + 100, -1, 32'h0);
    done_cnt = 0;
    quiet = 1'b1;
    for (int i = 0; i < FRAME + 100; i++) begin
      if (tr_done[i] === 1'b1) done_cnt++;
      if (tr_txd[i] !== 1'b1) quiet = 1'b0;
    end
    total++; if (done_cnt != 0) begin bad++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt); end
    total++; if (quiet !== 1'b1) begin bad++; $display("[TB] FAIL abort_line_idle: got %b expected 1", quiet); end
    exp_bytes = '{8'h43, 8'h30, 8'h46, 8'h46, 8'h45, 8'h45, 8'h34, 8'h32, 8'h0D, 8'h0A};
    pulse_start(32'hC0FFEE42);
    capture(FRAME + 10, -1, 32'h0);
    decode(0);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (dec_bytes[c] !== exp_bytes[c]) begin bad++; $display("[TB] FAIL abort_next_char%0d: got %h expected %h", c, dec_bytes[c], exp_bytes[c]); end
    end
    total++; if (dec_frame_ok !== 1'b1) begin bad++; $display("[TB] FAIL abort_next_framing: got %b expected 1", dec_frame_ok); end
    total++; if (tr_done[FRAME] !== 1'b1) begin bad++; $display("[TB] FAIL abort_next_done: got %b expected 1", tr_done[FRAME]); end
  endtask

`ifdef SM_UART_PARITY_EN
  task test_parity();
    logic exp_par[10];
    exp_bytes = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A};
    exp_par   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    pulse_start(32'h00000007);
    capture(FRAME + 10, -1, 32'h0);
    decode(0);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (dec_bytes[c] !== exp_bytes[c]) begin bad++; $display("[TB] FAIL par_char%0d: got %h expected %h", c, dec_bytes[c], exp_bytes[c]); end
      total++;
      if (dec_par[c] !== exp_par[c]) begin bad++; $display("[TB] FAIL par_bit%0d: got %b expected %b", c, dec_par[c], exp_par[c]); end
    end
    total++; if (tr_done[FRAME] !== 1'b1) begin bad++; $display("[TB] FAIL par_done_time: got %b expected 1", tr_done[FRAME]); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    data  = 32'h0;
    test_reset();
    test_full_frame();
    test_ignored_start();
    test_back_to_back();
    test_abort();
`ifdef SM_UART_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm_uart_hexdump.md
Name: sm_uart_hexdump

Overview:
- Debug UART transmitter downstream of the processor core's register-read port (regAddr/regData) on the board top.
- On a start pulse, snapshots a 32-bit word and sends it as 8 uppercase ASCII hex digits, MSB nibble first, followed by CR LF.
- Serial format is 8N1 on a single TX line.
- Drives the board UART_TXD pin so a host terminal can log register values.

Parameters:
- BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2.
- Baud counter width is $clog2(BAUD_DIV).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- data  input  32  word to dump; captured on the accepted start cycle.
- busy  output  1  high from the cycle after an accepted start until the frame completes.
- done  output  1  one-cycle pulse when the last stop bit has completed.
- txd  output  1  serial output; idle high.

Behaviour:
- Reset (async, any state): txd=1, busy=0, done=0, FSM=IDLE; all counters cleared.
  - Reset mid-character aborts the frame; txd returns high immediately.
  - No done pulse is generated for an aborted frame.
- Internal registers: 32-bit snapshot; 4-bit char index (0..9); 3-bit bit index; baud counter; 8-bit shift register.
- Char index mapping:
  - Index 0..7 selects nibble snapshot[31-4i -: 4].
  - Nibble 0-9 maps to 0x30+n; A-F maps to 0x41+(n-10), uppercase.
  - Index 8 = 0x0D, index 9 = 0x0A.
- FSM states and transitions:
  - IDLE: txd=1, busy=0. When start=1, capture data, load char 0, go to START. busy=1 from the next cycle.
  - START: txd=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first; each bit held BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: txd=1 for BAUD_DIV cycles.
    - If char index < 9: increment the index, load the next char, go to START.
    - Else go to IDLE; done=1 and busy=0 in the same cycle.
- Timing:
  - Start accepted at edge N: txd falls at edge N+1.
  - Each character occupies exactly 10*BAUD_DIV cycles, with no gap between characters.
  - Whole frame is 100*BAUD_DIV cycles; done asserts at edge N+1+100*BAUD_DIV.
- Boundary conditions:
  - start while busy=1 is ignored: no queueing, and the snapshot is unchanged.
  - start in the same cycle as done is accepted, giving back-to-back frames. txd stays high for exactly that one cycle, then the new start bit begins.
  - data changes after capture have no effect on the frame in flight.
  - Baud counter counts 0..BAUD_DIV-1 and wraps; bit boundaries occur at the wrap.

Optional Feature:
- Macro: SM_UART_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is sent between bit 7 and the stop bit, via a PARITY state of BAUD_DIV cycles.
  - A character becomes 11*BAUD_DIV cycles; the frame becomes 110*BAUD_DIV cycles.
- Undefined: 8N1 exactly as above; no PARITY state exists.

Test Plan (BAUD_DIV=4 unless noted):
1. Reset check: hold rst for 3 cycles, then release -> txd=1, busy=0, done=0; with no start for 50 cycles, txd stays 1.
2. Full frame: data=0x1234ABCD, start at edge 10.
   - Decoded bytes must be 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A.
   - txd falls at edge 11; done pulses exactly at edge 411; busy high for edges 11..410.
3. Ignored start and stale data: data=0x0000000F, start; at cycle 100 change data=0xFFFFFFFF and pulse start again.
   - Output must still be "0000000F\r\n"; only one done pulse.
4. Back-to-back: drive start=1 with data=0xDEADBEEF in the done cycle of a prior frame.
   - Exactly one idle-high cycle separates the frames; second frame decodes "DEADBEEF\r\n".
5. Mid-frame abort: assert rst at cycle 57 of a frame.
   - txd=1 in the same cycle (async); busy=0; no done.
   - A new start afterwards produces a clean, complete frame.
6. Parity build: with SM_UART_PARITY_EN defined and data=0x00000007, decode every character.
   - Parity bits: '0'(0x30)=0, '7'(0x37)=1, CR(0x0D)=1, LF(0x0A)=0.
   - done at edge start+1+440.
